pp_sequencer: RTL and testbench

PP_SEQUENCER -- requirements
Module: pp_sequencer

---
 rtl/pp_sequencer_pkg.sv | 37 +++
 rtl/digit_mul.sv | 15 +
 rtl/pp_sequencer.sv | 142 ++++++++++++++
 tb/tb_pp_sequencer.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/pp_sequencer_pkg.sv
// -----------------------------------------------------------------------------
// pp_sequencer_pkg
// Shared definitions for the partial-product multiply sequencer and the
// downstream accumulator that sums its partial products.
//   - State encodings (3-bit, IDLE plus six COMPUTE phases).
//   - align_partial(): places a 4x4 digit product at the bit position that
//     the given COMPUTE phase contributes to the 16-bit result.
// -----------------------------------------------------------------------------
package pp_sequencer_pkg;

    localparam int STATE_W = 3;

    localparam logic [2:0] ST_IDLE      = 3'b000;
    localparam logic [2:0] ST_COMPUTE_1 = 3'b001;
    localparam logic [2:0] ST_COMPUTE_2 = 3'b010;
    localparam logic [2:0] ST_COMPUTE_3 = 3'b011;
    localparam logic [2:0] ST_COMPUTE_4 = 3'b100;
    localparam logic [2:0] ST_COMPUTE_5 = 3'b101;
    localparam logic [2:0] ST_COMPUTE_6 = 3'b110;

    // Weight of each digit pair: lo*lo -> x1, cross terms -> x16, hi*hi -> x256.
    // Phases that do not accumulate yield zero.
    function automatic logic [15:0] align_partial(input logic [2:0] st,
                                                  input logic [7:0] p);
        logic [15:0] r;
        r = 16'h0000;
        case (st)
            ST_COMPUTE_1: r = {8'h00, p};
            ST_COMPUTE_2: r = {4'h0, p, 4'h0};
            ST_COMPUTE_3: r = {4'h0, p, 4'h0};
            ST_COMPUTE_4: r = {p, 8'h00};
            default:      r = 16'h0000;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/digit_mul.sv
// -----------------------------------------------------------------------------
// digit_mul
// Combinational 4-bit x 4-bit unsigned multiplier (one hex digit pair).
//   x, y : input digits
//   p    : 8-bit product
// -----------------------------------------------------------------------------
module digit_mul (
    input  logic [3:0] x,
    input  logic [3:0] y,
    output logic [7:0] p
);

    assign p = {4'h0, x} * {4'h0, y};

endmodule

// File: rtl/pp_sequencer.sv
// -----------------------------------------------------------------------------
// pp_sequencer
// Sequences an 8x8 unsigned multiply as four 4x4 digit products that an
// external accumulator sums; captures the accumulated result as the product.
//   clk, rst_n  : clock, asynchronous active-low reset
//   start       : request a multiply (accepted only in IDLE)
//   abort       : cancel an in-flight multiply (COMPUTE_1..COMPUTE_5)
//   op_a, op_b  : multiplicand / multiplier
//   acc_in      : running sum from the accumulator (bit 16 = overflow)
//   adder_en    : accumulate strobe (COMPUTE_1..COMPUTE_4)
//   adder_in    : shifted partial product for the current phase
//   state       : current FSM state
//   done        : accumulator clear strobe (COMPUTE_6)
//   busy        : high whenever not IDLE
//   product     : last completed result, held until the next completion
//   valid       : one-cycle pulse marking a new product
//   ovf         : sticky overflow seen at capture, cleared by next start
// -----------------------------------------------------------------------------
module pp_sequencer
    import pp_sequencer_pkg::*;
(
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic                abort,
    input  logic [7:0]          op_a,
    input  logic [7:0]          op_b,
    input  logic [16:0]         acc_in,
    output logic                adder_en,
    output logic [STATE_W-1:0]  state,
    output logic [15:0]         adder_in,
    output logic                done,
    output logic                busy,
    output logic [15:0]         product,
    output logic                valid,
    output logic                ovf
);

    logic [2:0]  state_q,   state_d;
    logic [7:0]  a_q,       a_d;
    logic [7:0]  b_q,       b_d;
    logic [15:0] product_q, product_d;
    logic        ovf_q,     ovf_d;
    // Remembers that the current COMPUTE_6 was reached by abort, so valid
    // stays low while done still clears the accumulator.
    logic        aborted_q, aborted_d;

    logic [3:0]  mul_x;
    logic [3:0]  mul_y;
    logic [7:0]  mul_p;

    // Single digit multiplier, operands steered by phase.
    always_comb begin
        mul_x = a_q[3:0];
        mul_y = b_q[3:0];
        case (state_q)
            ST_COMPUTE_2: mul_x = a_q[7:4];
            ST_COMPUTE_3: mul_y = b_q[7:4];
            ST_COMPUTE_4: begin
                mul_x = a_q[7:4];
                mul_y = b_q[7:4];
            end
            default: ;
        endcase
    end

    digit_mul u_digit_mul (
        .x (mul_x),
        .y (mul_y),
        .p (mul_p)
    );

    always_comb begin
        state_d   = state_q;
        a_d       = a_q;
        b_d       = b_q;
        product_d = product_q;
        ovf_d     = ovf_q;
        aborted_d = aborted_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d   = ST_COMPUTE_1;
                    a_d       = op_a;
                    b_d       = op_b;
                    ovf_d     = 1'b0;
                    aborted_d = 1'b0;
                end
            end
            ST_COMPUTE_1, ST_COMPUTE_2, ST_COMPUTE_3, ST_COMPUTE_4: begin
                if (abort) begin
                    state_d   = ST_COMPUTE_6;
                    aborted_d = 1'b1;
                end else begin
                    state_d = state_q + 3'd1;
                end
            end
            ST_COMPUTE_5: begin
                state_d = ST_COMPUTE_6;
                // Abort takes priority over the capture on the same edge.
                if (abort) begin
                    aborted_d = 1'b1;
                end else begin
                    product_d = acc_in[15:0];
                    ovf_d     = ovf_q | acc_in[16];
                end
            end
            ST_COMPUTE_6: state_d = ST_IDLE;
            default:      state_d = ST_IDLE;   // 3'b111 recovers
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            a_q       <= 8'h00;
            b_q       <= 8'h00;
            product_q <= 16'h0000;
            ovf_q     <= 1'b0;
            aborted_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            a_q       <= a_d;
            b_q       <= b_d;
            product_q <= product_d;
            ovf_q     <= ovf_d;
            aborted_q <= aborted_d;
        end
    end

    // Moore outputs: decoded from registered state and operands only.
    assign state    = state_q;
    assign adder_en = (state_q == ST_COMPUTE_1) || (state_q == ST_COMPUTE_2) ||
                      (state_q == ST_COMPUTE_3) || (state_q == ST_COMPUTE_4);
    assign adder_in = align_partial(state_q, mul_p);
    assign done     = (state_q == ST_COMPUTE_6);
    assign valid    = (state_q == ST_COMPUTE_6) && !aborted_q;
    assign busy     = (state_q != ST_IDLE);
    assign product  = product_q;
    assign ovf      = ovf_q;

endmodule

// File: tb/tb_pp_sequencer.sv
// -----------------------------------------------------------------------------
// tb_pp_sequencer
// Pairs pp_sequencer with a behavioural accumulator, checks every cycle
// against a phase-count reference model, and pins known products by hand.
// -----------------------------------------------------------------------------
module tb_pp_sequencer;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic        abort;
    logic [7:0]  op_a;
    logic [7:0]  op_b;
    logic [16:0] acc_in;
    logic        adder_en;
    logic [2:0]  state;
    logic [15:0] adder_in;
    logic        done;
    logic        busy;
    logic [15:0] product;
    logic        valid;
    logic        ovf;

    int vectors;
    int miscompares;

    pp_sequencer dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .abort    (abort),
        .op_a     (op_a),
        .op_b     (op_b),
        .acc_in   (acc_in),
        .adder_en (adder_en),
        .state    (state),
        .adder_in (adder_in),
        .done     (done),
        .busy     (busy),
        .product  (product),
        .valid    (valid),
        .ovf      (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural accumulator; acc_force16 injects an overflow bit.
    logic [16:0] acc;
    logic        acc_force16;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n)        acc <= '0;
        else if (done)     acc <= '0;
        else if (adder_en) acc <= acc + {1'b0, adder_in};
    end
    assign acc_in = acc | {acc_force16, 16'h0000};

    // Reference model: phase 0 = idle, 1..6 = compute steps.
    int m_phase, m_a, m_b, m_product;
    bit m_aborted, m_ovf;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_phase <= 0; m_a <= 0; m_b <= 0; m_product <= 0;
            m_aborted <= 0; m_ovf <= 0;
        end else if (m_phase == 0) begin
            if (start) begin
                m_phase <= 1; m_a <= int'(op_a); m_b <= int'(op_b);
                m_ovf <= 0; m_aborted <= 0;
            end
        end else if (m_phase <= 5) begin
            if (abort) begin
                m_phase <= 6; m_aborted <= 1;
            end else begin
                m_phase <= m_phase + 1;
                if (m_phase == 5) begin
                    m_product <= m_a * m_b;
                    m_ovf     <= m_ovf | acc_force16;
                end
            end
        end else begin
            m_phase <= 0;
        end
    end

    function automatic int model_adder(input int ph, input int a, input int b);
        case (ph)
            1: return (a % 16) * (b % 16);
            2: return (a / 16) * (b % 16) * 16;
            3: return (a % 16) * (b / 16) * 16;
            4: return (a / 16) * (b / 16) * 256;
            default: return 0;
        endcase
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Per-cycle compare against the model.
    always @(negedge clk) begin
        chk("state",    32'(state),    32'(m_phase));
        chk("busy",     32'(busy),     32'(m_phase != 0));
        chk("adder_en", 32'(adder_en), 32'(m_phase >= 1 && m_phase <= 4));
        chk("adder_in", 32'(adder_in), 32'(model_adder(m_phase, m_a, m_b)));
        chk("done",     32'(done),     32'(m_phase == 6));
        chk("valid",    32'(valid),    32'(m_phase == 6 && !m_aborted));
        chk("product",  32'(product),  32'(m_product));
        chk("ovf",      32'(ovf),      32'(m_ovf));
    end

    logic [15:0] seq_adder [1:6];
    logic [2:0]  seq_state [1:6];
    int          valid_cycle;
    int          done_cycle;

    // Issue one multiply and record six cycles of outputs; abort_at = phase
    // in which abort is raised (0 = none).
    task automatic run_op(input logic [7:0] a, input logic [7:0] b, input int abort_at);
        @(negedge clk);
        op_a = a; op_b = b; start = 1'b1;
        valid_cycle = 0; done_cycle = 0;
        for (int c = 1; c <= 6; c++) begin
            @(negedge clk);
            start = 1'b0;
            seq_adder[c] = adder_in;
            seq_state[c] = state;
            if (valid && valid_cycle == 0) valid_cycle = c;
            if (done && done_cycle == 0)   done_cycle = c;
            abort = (c == abort_at);
        end
        abort = 1'b0;
        @(negedge clk);
        $display("op 0x%02h*0x%02h abort_at=%0d -> product=0x%04h ovf=%0d valid_cycle=%0d done_cycle=%0d",
                 a, b, abort_at, product, ovf, valid_cycle, done_cycle);
    endtask

    initial begin
        int nvalid;
        logic [15:0] first_prod, second_prod;
        int first_vc, second_vc;
        vectors = 0; miscompares = 0;
        rst_n = 1'b0; start = 1'b0; abort = 1'b0; op_a = '0; op_b = '0;
        acc_force16 = 1'b0;
        #2;
        chk("reset_state", 32'(state), 32'h0);
        chk("reset_busy",  32'(busy),  32'h0);
        @(negedge clk);
        #2 rst_n = 1'b1;

        // 0x12*0x34
        run_op(8'h12, 8'h34, 0);
        chk("seq1_c1", 32'(seq_adder[1]), 32'h0008);
        chk("seq1_c2", 32'(seq_adder[2]), 32'h0040);
        chk("seq1_c3", 32'(seq_adder[3]), 32'h0060);
        chk("seq1_c4", 32'(seq_adder[4]), 32'h0300);
        chk("seq1_valid_cycle", 32'(valid_cycle), 32'd6);
        chk("seq1_product", 32'(product), 32'h03A8);

        // 0xFF*0xFF
        run_op(8'hFF, 8'hFF, 0);
        chk("ff_product", 32'(product), 32'hFE01);
        chk("ff_ovf",     32'(ovf),     32'h0);

        // 0x00*0xA7
        run_op(8'h00, 8'hA7, 0);
        for (int c = 1; c <= 4; c++) chk("zero_adder_in", 32'(seq_adder[c]), 32'h0);
        chk("zero_product",     32'(product),     32'h0000);
        chk("zero_valid_cycle", 32'(valid_cycle), 32'd6);

        // start held through the operation, operands change mid-op
        @(negedge clk);
        op_a = 8'h05; op_b = 8'h07; start = 1'b1;
        nvalid = 0; first_vc = 0; second_vc = 0; first_prod = '0; second_prod = '0;
        for (int c = 1; c <= 14; c++) begin
            @(negedge clk);
            if (c == 2) begin op_a = 8'h0B; op_b = 8'h0D; end
            if (c == 7) chk("held_idle_gap", 32'(state), 32'h0);
            if (c == 8) start = 1'b0;
            if (valid) begin
                nvalid++;
                if (nvalid == 1) begin first_prod = product; first_vc = c; end
                else begin second_prod = product; second_vc = c; end
            end
        end
        $display("held start -> valids=%0d first=0x%04h@%0d second=0x%04h@%0d",
                 nvalid, first_prod, first_vc, second_prod, second_vc);
        chk("held_valids",      32'(nvalid),      32'd2);
        chk("held_first_prod",  32'(first_prod),  32'h0023);
        chk("held_first_vc",    32'(first_vc),    32'd6);
        chk("held_second_prod", 32'(second_prod), 32'h008F);
        chk("held_second_vc",   32'(second_vc),   32'd13);

        // overflow injection at capture, then cleared by the next start
        acc_force16 = 1'b1;
        run_op(8'h12, 8'h34, 0);
        acc_force16 = 1'b0;
        chk("ovf_set",     32'(ovf),     32'h1);
        chk("ovf_product", 32'(product), 32'h03A8);

        // abort in COMPUTE_3
        run_op(8'h22, 8'h22, 3);
        chk("abort3_state_next", 32'(seq_state[4]), 32'h6);
        chk("abort3_done_cycle", 32'(done_cycle),   32'd4);
        chk("abort3_no_valid",   32'(valid_cycle),  32'd0);
        chk("abort3_product",    32'(product),      32'h03A8);
        chk("abort3_ovf_clear",  32'(ovf),          32'h0);

        // abort in COMPUTE_5 beats the capture
        run_op(8'h33, 8'h33, 5);
        chk("abort5_no_valid", 32'(valid_cycle), 32'd0);
        chk("abort5_product",  32'(product),     32'h03A8);

        // abort in IDLE is ignored
        @(negedge clk); abort = 1'b1;
        @(negedge clk); abort = 1'b0;
        chk("abort_idle_state", 32'(state), 32'h0);

        // reset in COMPUTE_2
        @(negedge clk);
        op_a = 8'h12; op_b = 8'h34; start = 1'b1;
        @(negedge clk); start = 1'b0;
        @(negedge clk);
        chk("pre_reset_state", 32'(state), 32'h2);
        #3 rst_n = 1'b0;
        #1;
        chk("rst_state",    32'(state),    32'h0);
        chk("rst_adder_en", 32'(adder_en), 32'h0);
        chk("rst_adder_in", 32'(adder_in), 32'h0);
        chk("rst_done",     32'(done),     32'h0);
        chk("rst_valid",    32'(valid),    32'h0);
        chk("rst_busy",     32'(busy),     32'h0);
        chk("rst_product",  32'(product),  32'h0);
        chk("rst_ovf",      32'(ovf),      32'h0);
        @(negedge clk);
        #3 rst_n = 1'b1;
        run_op(8'h12, 8'h34, 0);
        chk("post_reset_product", 32'(product),     32'h03A8);
        chk("post_reset_valid",   32'(valid_cycle), 32'd6);

        repeat (2) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
